// File: rtl/param_grid_reader.sv
// param_grid_reader
// On a start pulse, takes a snapshot of a flattened n_y_p x n_x_p grid of
// width_p-bit values. It then streams the values out one per beat in
// row-major order (row outer, column inner) over a valid/ready handshake.
// The stream is followed by a single-cycle done pulse.
//
// Ports:
//   clk      rising-edge clock
//   rst      asynchronous active-high reset
//   start_i  snapshot/readout request, only looked at in IDLE
//   grid_i   flattened grid, element [r][c] at ((r*n_x_p+c)*width_p) +: width_p
//   busy_o   readout in progress (cycle after start until the done cycle)
//   v_o      data_o/row_o/col_o/last_o describe a valid beat
//   ready_i  consumer accepts the beat when v_o & ready_i
//   data_o   current element
//   row_o    row index of the current element
//   col_o    column index of the current element
//   last_o   current beat is the bottom-right element
//   done_o   one-cycle pulse after the last beat is accepted
module param_grid_reader #(
  parameter int n_x_p   = 4,
  parameter int n_y_p   = 4,
  parameter int width_p = 32,
  localparam int row_w_lp = (n_y_p > 1) ? $clog2(n_y_p) : 1,
  localparam int col_w_lp = (n_x_p > 1) ? $clog2(n_x_p) : 1
) (
  input  logic                             clk,
  input  logic                             rst,
  input  logic                             start_i,
  input  logic [n_y_p*n_x_p*width_p-1:0]   grid_i,
  output logic                             busy_o,
  output logic                             v_o,
  input  logic                             ready_i,
  output logic [width_p-1:0]               data_o,
  output logic [row_w_lp-1:0]              row_o,
  output logic [col_w_lp-1:0]              col_o,
  output logic                             last_o,
  output logic                             done_o
);

  typedef enum logic [1:0] {
    ST_IDLE   = 2'd0,
    ST_STREAM = 2'd1,
    ST_DONE   = 2'd2
  } state_e;

  // Full-width index limits so non-power-of-two dimensions compare correctly.
  localparam logic [row_w_lp-1:0] row_max_lp = row_w_lp'(n_y_p - 1);
  localparam logic [col_w_lp-1:0] col_max_lp = col_w_lp'(n_x_p - 1);

  state_e                state_q;
  logic [width_p-1:0]    snap_q [n_y_p][n_x_p];
  logic [row_w_lp-1:0]   row_q;
  logic [col_w_lp-1:0]   col_q;
  logic                  busy_q;
  logic                  v_q;
  logic                  last_q;
  logic                  done_q;

  logic [row_w_lp-1:0]   row_d;
  logic [col_w_lp-1:0]   col_d;
  logic                  last_d;

  // Next row-major position after the current beat. It is only used when the
  // current beat is not the last, so the row increment never leaves the grid.
  always_comb begin
    row_d = row_q;
    col_d = col_q;
    if (col_q == col_max_lp) begin
      col_d = col_w_lp'(0);
      row_d = row_q + row_w_lp'(1);
    end else begin
      col_d = col_q + col_w_lp'(1);
    end
    last_d = (row_d == row_max_lp) && (col_d == col_max_lp);
  end

  // Readout FSM: snapshot capture, beat sequencing and registered status outputs.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q <= ST_IDLE;
      row_q   <= row_w_lp'(0);
      col_q   <= col_w_lp'(0);
      busy_q  <= 1'b0;
      v_q     <= 1'b0;
      last_q  <= 1'b0;
      done_q  <= 1'b0;
      for (int r = 0; r < n_y_p; r++) begin
        for (int c = 0; c < n_x_p; c++) begin
          snap_q[r][c] <= {width_p{1'b0}};
        end
      end
    end else begin
      case (state_q)
        ST_IDLE: begin
          done_q <= 1'b0;
          if (start_i) begin
            for (int r = 0; r < n_y_p; r++) begin
              for (int c = 0; c < n_x_p; c++) begin
                snap_q[r][c] <= grid_i[(r*n_x_p+c)*width_p +: width_p];
              end
            end
            row_q   <= row_w_lp'(0);
            col_q   <= col_w_lp'(0);
            busy_q  <= 1'b1;
            v_q     <= 1'b1;
            // A 1x1 grid's first beat is also its last.
            last_q  <= (row_max_lp == row_w_lp'(0)) && (col_max_lp == col_w_lp'(0));
            state_q <= ST_STREAM;
          end
        end
        ST_STREAM: begin
          if (v_q && ready_i) begin
            if (last_q) begin
              busy_q  <= 1'b0;
              v_q     <= 1'b0;
              last_q  <= 1'b0;
              done_q  <= 1'b1;
              state_q <= ST_DONE;
            end else begin
              row_q  <= row_d;
              col_q  <= col_d;
              last_q <= last_d;
            end
          end
        end
        ST_DONE: begin
          // start_i is deliberately not looked at here.
          done_q  <= 1'b0;
          state_q <= ST_IDLE;
        end
        default: begin
          busy_q  <= 1'b0;
          v_q     <= 1'b0;
          last_q  <= 1'b0;
          done_q  <= 1'b0;
          state_q <= ST_IDLE;
        end
      endcase
    end
  end

  assign busy_o = busy_q;
  assign v_o    = v_q;
  assign last_o = last_q;
  assign done_o = done_q;
  assign row_o  = row_q;
  assign col_o  = col_q;
  // Element select from registered indices; stable while a beat is stalled.
  assign data_o = snap_q[row_q][col_q];

endmodule

// File: tb/tb_param_grid_reader.sv
module tb_param_grid_reader;

  logic clk = 1'b0;
  logic rst = 1'b1;
  always #5 clk = ~clk;

  int checks = 0;
  int errors = 0;

  // 4x4, 32-bit instance
  logic         start0 = 1'b0, ready0 = 1'b0;
  logic [511:0] grid0 = '0;
  logic         busy0, v0, last0, done0;
  logic [31:0]  data0;
  logic [1:0]   row0, col0;

  // 3 columns x 2 rows, 8-bit instance
  logic         start1 = 1'b0, ready1 = 1'b0;
  logic [47:0]  grid1 = '0;
  logic         busy1, v1, last1, done1;
  logic [7:0]   data1;
  logic [0:0]   row1;
  logic [1:0]   col1;

  // 1x1, 8-bit instance
  logic         start2 = 1'b0, ready2 = 1'b0;
  logic [7:0]   grid2 = '0;
  logic         busy2, v2, last2, done2;
  logic [7:0]   data2;
  logic [0:0]   row2, col2;

  param_grid_reader #(.n_x_p(4), .n_y_p(4), .width_p(32)) dut0 (
    .clk(clk), .rst(rst), .start_i(start0), .grid_i(grid0), .busy_o(busy0),
    .v_o(v0), .ready_i(ready0), .data_o(data0), .row_o(row0), .col_o(col0),
    .last_o(last0), .done_o(done0));

  param_grid_reader #(.n_x_p(3), .n_y_p(2), .width_p(8)) dut1 (
    .clk(clk), .rst(rst), .start_i(start1), .grid_i(grid1), .busy_o(busy1),
    .v_o(v1), .ready_i(ready1), .data_o(data1), .row_o(row1), .col_o(col1),
    .last_o(last1), .done_o(done1));

  param_grid_reader #(.n_x_p(1), .n_y_p(1), .width_p(8)) dut2 (
    .clk(clk), .rst(rst), .start_i(start2), .grid_i(grid2), .busy_o(busy2),
    .v_o(v2), .ready_i(ready2), .data_o(data2), .row_o(row2), .col_o(col2),
    .last_o(last2), .done_o(done2));

  typedef struct {
    logic       start;
    logic       ready;
    logic       v;
    logic [0:0] row;
    logic [1:0] col;
    logic [7:0] data;
    logic       last;
    logic       done;
    logic       busy;
  } vec_t;

  vec_t vecs [14];

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s actual=%0h expected=%0h", name, act, exp);
    end
  endtask

  function automatic logic [511:0] fill4(input logic [31:0] base);
    logic [511:0] g;
    g = '0;
    for (int r = 0; r < 4; r++)
      for (int c = 0; c < 4; c++)
        g[(r*4+c)*32 +: 32] = base + 32'(16*r + c);
    return g;
  endfunction

  // Full 4x4 readout with a scoreboard index k; pat 0 = always ready,
  // pat 1 = ready on every third cycle. With disturb set, grid_i is trashed
  // after the start edge and start_i is pulsed during the stream and DONE.
  task automatic run4(input int pat, input logic [31:0] base, input bit disturb);
    int k, vcnt, bcnt, dcnt, after;
    bit rdy;
    k = 0; vcnt = 0; bcnt = 0; dcnt = 0; after = 0;
    chk("idle_v", {63'd0, v0}, 64'd0);
    start0 = 1'b1;
    step();
    start0 = 1'b0;
    if (disturb) grid0 = '1;
    chk("first_valid_latency", {63'd0, v0}, 64'd1);
    for (int cyc = 0; cyc < 120 && after < 3; cyc++) begin
      rdy = (pat == 0) ? 1'b1 : (cyc % 3 == 0);
      ready0 = rdy;
      start0 = disturb && ((v0 && (cyc % 5 == 2)) || done0);
      if (busy0) bcnt++;
      if (v0) begin
        vcnt++;
        if (k >= 16) begin
          chk("extra_beat", 64'(k), 64'd15);
        end else begin
          chk($sformatf("row[%0d]", k), {62'd0, row0}, 64'(k / 4));
          chk($sformatf("col[%0d]", k), {62'd0, col0}, 64'(k % 4));
          chk($sformatf("data[%0d]", k), {32'd0, data0}, {32'd0, base + 32'(16*(k/4) + k%4)});
          chk($sformatf("last[%0d]", k), {63'd0, last0}, {63'd0, k == 15});
        end
        if (rdy) k++;
      end
      if (done0) begin
        dcnt++;
        chk("done_after_last", 64'(k), 64'd16);
        chk("done_busy_low", {63'd0, busy0}, 64'd0);
      end
      if (dcnt > 0) after++;
      step();
    end
    start0 = 1'b0;
    ready0 = 1'b0;
    chk("accepts", 64'(k), 64'd16);
    chk("done_pulses", 64'(dcnt), 64'd1);
    chk("busy_eq_valid", 64'(bcnt), 64'(vcnt));
    if (pat == 0) chk("busy_cycles", 64'(bcnt), 64'd16);
  endtask

  initial begin
    // 3x2 vectors: inputs applied this cycle, outputs expected this cycle.
    //            start  ready  v     row   col    data   last  done  busy
    vecs[0]  = '{1'b1, 1'b0, 1'b0, 1'b0, 2'd0, 8'h00, 1'b0, 1'b0, 1'b0};
    vecs[1]  = '{1'b0, 1'b1, 1'b1, 1'b0, 2'd0, 8'hA0, 1'b0, 1'b0, 1'b1};
    vecs[2]  = '{1'b0, 1'b0, 1'b1, 1'b0, 2'd1, 8'hA1, 1'b0, 1'b0, 1'b1};
    vecs[3]  = '{1'b1, 1'b0, 1'b1, 1'b0, 2'd1, 8'hA1, 1'b0, 1'b0, 1'b1};
    vecs[4]  = '{1'b0, 1'b1, 1'b1, 1'b0, 2'd1, 8'hA1, 1'b0, 1'b0, 1'b1};
    vecs[5]  = '{1'b0, 1'b1, 1'b1, 1'b0, 2'd2, 8'hA2, 1'b0, 1'b0, 1'b1};
    vecs[6]  = '{1'b0, 1'b0, 1'b1, 1'b1, 2'd0, 8'hB0, 1'b0, 1'b0, 1'b1};
    vecs[7]  = '{1'b0, 1'b1, 1'b1, 1'b1, 2'd0, 8'hB0, 1'b0, 1'b0, 1'b1};
    vecs[8]  = '{1'b0, 1'b1, 1'b1, 1'b1, 2'd1, 8'hB1, 1'b0, 1'b0, 1'b1};
    vecs[9]  = '{1'b0, 1'b0, 1'b1, 1'b1, 2'd2, 8'hB2, 1'b1, 1'b0, 1'b1};
    vecs[10] = '{1'b0, 1'b1, 1'b1, 1'b1, 2'd2, 8'hB2, 1'b1, 1'b0, 1'b1};
    vecs[11] = '{1'b1, 1'b1, 1'b0, 1'b0, 2'd0, 8'h00, 1'b0, 1'b1, 1'b0};
    vecs[12] = '{1'b0, 1'b1, 1'b0, 1'b0, 2'd0, 8'h00, 1'b0, 1'b0, 1'b0};
    vecs[13] = '{1'b0, 1'b1, 1'b0, 1'b0, 2'd0, 8'h00, 1'b0, 1'b0, 1'b0};

    for (int r = 0; r < 2; r++)
      for (int c = 0; c < 3; c++)
        grid1[(r*3+c)*8 +: 8] = 8'hA0 + 8'(16*r + c);
    grid0 = fill4(32'd0);
    grid2 = 8'h5A;

    // Reset state
    step();
    step();
    chk("rst_v", {63'd0, v0}, 64'd0);
    chk("rst_busy", {63'd0, busy0}, 64'd0);
    chk("rst_data", {32'd0, data0}, 64'd0);
    rst = 1'b0;
    step();
    chk("idle_done", {63'd0, done0}, 64'd0);
    chk("idle_last", {63'd0, last0}, 64'd0);

    // 3x2 table with backpressure, start ignored in STREAM and DONE
    for (int i = 0; i < 14; i++) begin
      start1 = vecs[i].start;
      ready1 = vecs[i].ready;
      chk($sformatf("t3x2[%0d].v", i), {63'd0, v1}, {63'd0, vecs[i].v});
      chk($sformatf("t3x2[%0d].last", i), {63'd0, last1}, {63'd0, vecs[i].last});
      chk($sformatf("t3x2[%0d].done", i), {63'd0, done1}, {63'd0, vecs[i].done});
      chk($sformatf("t3x2[%0d].busy", i), {63'd0, busy1}, {63'd0, vecs[i].busy});
      if (vecs[i].v) begin
        chk($sformatf("t3x2[%0d].row", i), {63'd0, row1}, {63'd0, vecs[i].row});
        chk($sformatf("t3x2[%0d].col", i), {62'd0, col1}, {62'd0, vecs[i].col});
        chk($sformatf("t3x2[%0d].data", i), {56'd0, data1}, {56'd0, vecs[i].data});
      end
      step();
    end
    start1 = 1'b0;
    ready1 = 1'b0;

    // 1x1: single last beat, held through one stall, then done
    start2 = 1'b1;
    step();
    start2 = 1'b0;
    chk("1x1_v", {63'd0, v2}, 64'd1);
    chk("1x1_last", {63'd0, last2}, 64'd1);
    chk("1x1_data", {56'd0, data2}, 64'h5A);
    chk("1x1_busy", {63'd0, busy2}, 64'd1);
    step();
    chk("1x1_stall_v", {63'd0, v2}, 64'd1);
    ready2 = 1'b1;
    step();
    ready2 = 1'b0;
    chk("1x1_done", {63'd0, done2}, 64'd1);
    chk("1x1_done_v", {63'd0, v2}, 64'd0);
    step();
    chk("1x1_done_clear", {63'd0, done2}, 64'd0);

    // 4x4 full speed, then backpressure with snapshot disturbance
    run4(0, 32'd0, 1'b0);
    grid0 = fill4(32'd0);
    run4(1, 32'd0, 1'b1);

    // Reset while beat 5 is presented
    grid0 = fill4(32'd0);
    start0 = 1'b1;
    step();
    start0 = 1'b0;
    ready0 = 1'b1;
    for (int i = 0; i < 4; i++) step();
    ready0 = 1'b0;
    chk("beat5_row", {62'd0, row0}, 64'd1);
    chk("beat5_col", {62'd0, col0}, 64'd0);
    chk("beat5_data", {32'd0, data0}, 64'd16);
    rst = 1'b1;
    #1;
    chk("async_rst_v", {63'd0, v0}, 64'd0);
    chk("async_rst_busy", {63'd0, busy0}, 64'd0);
    step();
    rst = 1'b0;
    for (int i = 0; i < 3; i++) begin
      chk($sformatf("post_rst_v[%0d]", i), {63'd0, v0}, 64'd0);
      chk($sformatf("post_rst_done[%0d]", i), {63'd0, done0}, 64'd0);
      step();
    end
    grid0 = fill4(32'h1000);
    run4(0, 32'h1000, 1'b0);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule

// File: doc/param_grid_reader.md
Name: param_grid_reader

Overview:
- Readout counterpart to the parameter-grid fan-out pattern, where a 2-D integer table drives an n_y_p x n_x_p array of per-tile instances.
- This block does the reverse: on a start pulse it snapshots a flattened 2-D grid of per-tile values.
- It then streams the values out one per beat in row-major order (r outer, c inner), using a valid/ready handshake.
- Used by test benches and debug paths to read back per-tile configuration or status.

Parameters:
- n_x_p, 4, columns per row (>=1)
- n_y_p, 4, rows (>=1)
- width_p, 32, bits per grid element

Ports:
- clk  input  1  rising-edge clock
- rst  input  1  asynchronous, active-high reset
- start_i  input  1  request a snapshot and readout; sampled only in IDLE
- grid_i  input  n_y_p*n_x_p*width_p  flattened grid; element [r][c] is at bits ((r*n_x_p+c)*width_p) +: width_p
- busy_o  output  1  high from the cycle after an accepted start until done_o
- v_o  output  1  data_o/row_o/col_o valid
- ready_i  input  1  consumer accepts a beat when v_o & ready_i
- data_o  output  width_p  current element
- row_o  output  max(1,$clog2(n_y_p))  row index of current element
- col_o  output  max(1,$clog2(n_x_p))  column index of current element
- last_o  output  1  current beat is [n_y_p-1][n_x_p-1]
- done_o  output  1  single-cycle pulse after the last beat is accepted

Behaviour:
- Reset (async assert, sync deassert by the environment):
  - state=IDLE; busy_o=0, v_o=0, last_o=0, done_o=0.
  - data_o, row_o, col_o all 0; snapshot register cleared to 0.
- States: IDLE, STREAM, DONE.
- IDLE:
  - If start_i=1 at a clock edge, capture all of grid_i into the snapshot register, set r=0, c=0, go to STREAM.
  - busy_o and v_o rise in the cycle after the start edge. Start-to-first-valid latency is 1 cycle.
- STREAM:
  - v_o=1.
  - data_o = snapshot[r][c] (combinational from the registered indices).
  - row_o=r, col_o=c, last_o=(r==n_y_p-1 && c==n_x_p-1).
  - If v_o & ready_i:
    - if last_o, go to DONE;
    - else if c==n_x_p-1, set c=0 and r=r+1;
    - else c=c+1.
  - If ready_i=0, all outputs hold stable: no data_o/row_o/col_o change while v_o=1 and the beat is unaccepted.
  - v_o never drops in STREAM without an acceptance.
- DONE:
  - Lasts one cycle: done_o=1, v_o=0, busy_o=0 in that cycle.
  - Next state is IDLE unconditionally.
  - start_i during the DONE cycle is ignored; a new start is accepted only in IDLE.
- Throughput: one beat per cycle while ready_i=1. A full readout takes exactly n_x_p*n_y_p accepting cycles.
- Snapshot isolation: grid_i changes after the start edge do not affect the stream.
- start_i asserted in STREAM or DONE is ignored. It is not queued.
- Degenerate 1x1 grid (n_x_p=n_y_p=1): one beat with last_o=1, then DONE.
- Index counters never exceed n_y_p-1 / n_x_p-1. No wrap beyond the grid.
- rst asserted mid-STREAM:
  - immediately v_o=0, busy_o=0, state=IDLE;
  - no done_o pulse; remaining beats are discarded.
- Counters are sized at max(1,$clog2(n)). Comparisons use full-width constants so non-power-of-two dimensions work.

Test Plan:
- Default 4x4, width_p=32, grid[r][c]=16*r+c, start pulse, ready_i=1: 16 beats data 0,1,2,3,16,...,51, first beat 1 cycle after start; last_o only on beat 16 (row=3,col=3); done_o pulse the next cycle; busy_o high exactly 16 cycles.
- Backpressure with ready_i toggling 1,0,0,1,...: each value appears exactly once, in order; data_o/row_o/col_o stable through every stalled cycle; 16 acceptances total.
- Snapshot: start, then on the next cycle change grid_i to all 0xFFFFFFFF: stream still emits 16*r+c values; start_i pulses during the stream produce no extra beats and no second done_o.
- n_x_p=3, n_y_p=2, width_p=8: row/col sequence (0,0)(0,1)(0,2)(1,0)(1,1)(1,2); last_o on (1,2) only. Separately, 1x1: a single beat with last_o=1, then done_o.
- Reset at beat 5 of a 4x4 readout: v_o and busy_o low immediately (async), no done_o; a subsequent start restarts from (0,0) with fresh snapshot data.
